// File: rtl/fifo_stim_gen_if.sv
// FIFO-facing stimulus bus: write data, write/read enables and injected DUT reset.
interface fifo_stim_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  dut_rst_n;

  modport master (output data_in, wr_en, rd_en, dut_rst_n);
  modport slave  (input  data_in, wr_en, rd_en, dut_rst_n);
endinterface

// File: rtl/fifo_stim_gen.sv
// LFSR-driven FIFO stimulus engine: NUM_TXN registered stimulus cycles per run,
// random / fill-drain / simultaneous traffic, reproducible from SEED on every start.
module fifo_stim_gen #(
  parameter int          DATA_WIDTH = 16,
  parameter int          DEPTH      = 8,
  parameter int          NUM_TXN    = 1000,
  parameter int          WR_THRESH  = 179,
  parameter int          RD_THRESH  = 77,
  parameter int          RST_THRESH = 5,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  fifo_stim_gen_if.master        fifo,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            txn_count
);
  localparam logic [31:0]   MASK     = 32'h8020_0003;
  localparam logic [31:0]   SEED_NZ  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam int            PW       = $clog2(2 * DEPTH);
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * DEPTH - 1);
  localparam logic [31:0]   LAST_TXN = 32'(NUM_TXN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  wr;
    logic                  rd;
    logic                  rst_n;
  } stim_t;

  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? MASK : 32'd0);
  endfunction

  // Mode 3 falls into the random branch on purpose.
  function automatic stim_t gen(input logic [1:0] m, input logic [31:0] l,
                                input logic [PW-1:0] ph);
    stim_t s;
    s.data  = l[DATA_WIDTH-1:0];
    s.wr    = 1'b1;
    s.rd    = 1'b1;
    s.rst_n = 1'b1;
    case (m)
      2'd1: begin
        s.wr = (ph < DEPTH_P);
        s.rd = !(ph < DEPTH_P);
      end
      2'd2: ;
      default: begin
        s.wr    = {1'b0, l[31:24]} < 9'(WR_THRESH);
        s.rd    = {1'b0, l[23:16]} < 9'(RD_THRESH);
        s.rst_n = !({1'b0, l[15:8]} < 9'(RST_THRESH));
      end
    endcase
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] phase_q, phase_d, phase_s;
  stim_t         stim_q, stim_d;
  logic [31:0]   txn_d;
  logic          busy_d, done_d;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    stim_d  = stim_q;
    txn_d   = txn_count;
    busy_d  = busy;
    done_d  = done;
    phase_s = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

    if (abort) begin
      state_d      = IDLE;
      stim_d.wr    = 1'b0;
      stim_d.rd    = 1'b0;
      stim_d.rst_n = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            mode_d  = mode;
            lfsr_d  = step(SEED_NZ);
            phase_d = '0;
            txn_d   = 32'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            stim_d  = gen(mode, lfsr_d, '0);
          end
        end
        RUN: begin
          if (txn_count == LAST_TXN) begin
            state_d      = DONE;
            stim_d.wr    = 1'b0;
            stim_d.rd    = 1'b0;
            stim_d.rst_n = 1'b1;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            txn_d   = txn_count + 32'd1;
            lfsr_d  = step(lfsr_q);
            phase_d = phase_s;
            stim_d  = gen(mode_q, lfsr_d, phase_s);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_NZ;
      mode_q    <= 2'd0;
      phase_q   <= '0;
      stim_q    <= '{data: '0, wr: 1'b0, rd: 1'b0, rst_n: 1'b1};
      txn_count <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      stim_q    <= stim_d;
      txn_count <= txn_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign fifo.data_in   = stim_q.data;
  assign fifo.wr_en     = stim_q.wr;
  assign fifo.rd_en     = stim_q.rd;
  assign fifo.dut_rst_n = stim_q.rst_n;
endmodule

// File: tb/tb_fifo_stim_gen.sv
// Directed bench for fifo_stim_gen: three instances (20-txn, 40-txn fill-drain, defaults)
// sharing control inputs, checked against hand values and an LFSR reference.
module tb_fifo_stim_gen;
  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [1:0] mode;

  fifo_stim_gen_if #(.DATA_WIDTH(16)) bus_a ();
  fifo_stim_gen_if #(.DATA_WIDTH(16)) bus_b ();
  fifo_stim_gen_if #(.DATA_WIDTH(16)) bus_d ();
  logic        busy_a, done_a, busy_b, done_b, busy_d, done_d;
  logic [31:0] txn_a, txn_b, txn_d;

  fifo_stim_gen #(.NUM_TXN(20), .DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .fifo(bus_a), .busy(busy_a), .done(done_a), .txn_count(txn_a));
  fifo_stim_gen #(.NUM_TXN(40), .DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .fifo(bus_b), .busy(busy_b), .done(done_b), .txn_count(txn_b));
  fifo_stim_gen u_d (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .fifo(bus_d), .busy(busy_d), .done(done_d), .txn_count(txn_d));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  // {data_in, wr_en, rd_en, dut_rst_n} expected in random mode with default thresholds
  function automatic logic [18:0] rnd_stim(input logic [31:0] l);
    return {l[15:0], l[31:24] < 8'd179, l[23:16] < 8'd77, !(l[15:8] < 8'd5)};
  endfunction

  typedef struct {
    int   t;
    logic wr;
    logic rd;
    logic busy;
    logic done;
    int   txn;
  } vec_t;

  localparam logic [52:0] RST_PK = {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};

  initial begin
    vec_t        tbl [8];
    int          t;
    logic [31:0] l;
    int          wrc, rstlow;

    tbl[0] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{2,  1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[2] = '{10, 1'b1, 1'b1, 1'b1, 1'b0, 9};
    tbl[3] = '{19, 1'b1, 1'b1, 1'b1, 1'b0, 18};
    tbl[4] = '{20, 1'b1, 1'b1, 1'b1, 1'b0, 19};
    tbl[5] = '{21, 1'b0, 1'b0, 1'b0, 1'b1, 19};
    tbl[6] = '{22, 1'b0, 1'b0, 1'b0, 1'b1, 19};
    tbl[7] = '{25, 1'b0, 1'b0, 1'b0, 1'b1, 19};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    tick(); tick();
    chk("reset_a", 64'({bus_a.data_in, bus_a.wr_en, bus_a.rd_en, bus_a.dut_rst_n, busy_a, done_a, txn_a}), 64'(RST_PK));
    chk("reset_b", 64'({bus_b.data_in, bus_b.wr_en, bus_b.rd_en, bus_b.dut_rst_n, busy_b, done_b, txn_b}), 64'(RST_PK));
    chk("reset_d", 64'({bus_d.data_in, bus_d.wr_en, bus_d.rd_en, bus_d.dut_rst_n, busy_d, done_d, txn_d}), 64'(RST_PK));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", 64'({busy_a, done_a, busy_d, done_d, bus_d.wr_en}), 64'd0);
    end

    // simultaneous mode, 20-txn instance, table-driven
    mode = 2'd2; start = 1'b1; tick(); start = 1'b0; t = 1;
    chk("m2_first_data", 64'(bus_a.data_in), 64'h8003);
    for (int i = 0; i < 8; i++) begin
      while (t < tbl[i].t) begin tick(); t++; end
      chk($sformatf("m2_tick%0d", tbl[i].t),
          64'({bus_a.wr_en, bus_a.rd_en, bus_a.dut_rst_n, busy_a, done_a, txn_a}),
          64'({tbl[i].wr, tbl[i].rd, 1'b1, tbl[i].busy, tbl[i].done, 32'(tbl[i].txn)}));
    end

    // abort from DONE (u_a) and from RUN (u_b, u_d)
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_done", 64'({busy_a, done_a, bus_a.wr_en, bus_a.rd_en}), 64'd0);
    chk("abort_run", 64'({busy_b, done_b, bus_b.wr_en, bus_b.rd_en, bus_b.dut_rst_n}), 64'd1);

    // fill-drain, 40-txn instance, DEPTH 8
    mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
    mode = 2'd2;
    for (int n = 1; n <= 40; n++) begin
      chk($sformatf("m1_txn%0d", n - 1),
          64'({bus_b.wr_en, bus_b.rd_en, bus_b.dut_rst_n, txn_b}),
          64'({((n - 1) % 16) < 8, ((n - 1) % 16) >= 8, 1'b1, 32'(n - 1)}));
      tick();
    end
    chk("m1_done", 64'({done_b, busy_b, bus_b.wr_en, bus_b.rd_en, txn_b}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd39}));
    abort = 1'b1; tick(); abort = 1'b0;

    // random mode twice (second run via mode 3), full 1000 cycles vs reference
    for (int r = 0; r < 2; r++) begin
      mode = (r == 0) ? 2'd0 : 2'd3;
      start = 1'b1; tick(); start = 1'b0;
      if (r == 0) chk("m0_first_data", 64'(bus_d.data_in), 64'h8003);
      l = 32'hACE1_0001; wrc = 0; rstlow = 0;
      for (int n = 0; n < 1000; n++) begin
        l = step(l);
        chk($sformatf("m0_r%0d_txn%0d", r, n),
            64'({bus_d.data_in, bus_d.wr_en, bus_d.rd_en, bus_d.dut_rst_n}), 64'(rnd_stim(l)));
        if (bus_d.wr_en) wrc++;
        if (!bus_d.dut_rst_n) rstlow++;
        tick();
      end
      chk("m0_end", 64'({done_d, busy_d, bus_d.wr_en, txn_d}), 64'({1'b1, 1'b0, 1'b0, 32'd999}));
      chk("m0_wr_duty", 64'(wrc >= 600 && wrc <= 800), 64'd1);
      chk("m0_rst_low", 64'(rstlow > 0), 64'd1);
    end

    // abort at txn 7 then restart
    mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("ab_at7", 64'(txn_d), 64'd7);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_quiet", 64'({busy_d, done_d, bus_d.wr_en, bus_d.rd_en, bus_d.dut_rst_n}), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ab_restart", 64'({busy_d, txn_d, bus_d.data_in}), 64'({1'b1, 32'd0, 16'h8003}));

    // mid-run reset with start held, then immediate rerun
    start = 1'b1;
    repeat (500) tick();
    chk("mr_at500", 64'(txn_d), 64'd500);
    rst_n = 1'b0; tick();
    chk("mr_reset", 64'({bus_d.data_in, bus_d.wr_en, bus_d.rd_en, bus_d.dut_rst_n, busy_d, done_d, txn_d}), 64'(RST_PK));
    rst_n = 1'b1; tick();
    chk("mr_rerun", 64'({busy_d, done_d, txn_d, bus_d.data_in}), 64'({1'b1, 1'b0, 32'd0, 16'h8003}));
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
